// File: rtl/ppg_pkg.sv
// Shared types and default sizing for the PPG window statistics block.
package ppg_pkg;

    localparam int WINDOW_LOG2_DEF = 6;
    localparam int DATA_W_DEF      = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        LOAD
    } ppg_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] red_dc;
        logic [DATA_W_DEF-1:0] red_ac;
        logic [DATA_W_DEF-1:0] ir_dc;
        logic [DATA_W_DEF-1:0] ir_ac;
    } ppg_rec_t;

endpackage

// File: rtl/ppg_window_stats_if.sv
// Result record bus from the window statistics block to the SpO2/ratio stage.
interface ppg_window_stats_if #(
    parameter int DATA_W = 8
);
    logic              Stats_Valid;
    logic              Stats_Ready;
    logic [DATA_W-1:0] RED_DC;
    logic [DATA_W-1:0] RED_AC;
    logic [DATA_W-1:0] IR_DC;
    logic [DATA_W-1:0] IR_AC;

    modport master (output Stats_Valid, RED_DC, RED_AC, IR_DC, IR_AC, input Stats_Ready);
    modport slave  (input Stats_Valid, RED_DC, RED_AC, IR_DC, IR_AC, output Stats_Ready);
endinterface

// File: rtl/ppg_chan_acc.sv
// One channel's window accumulator: running sum, min, max and sample count.
// Latency: a strobed sample is reflected one cycle later.
// Backpressure: none; strobes beyond a full window are dropped silently.
module ppg_chan_acc #(
    parameter int WINDOW_LOG2 = 6,
    parameter int DATA_W      = 8
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              clr,
    input  logic              stb,
    input  logic [DATA_W-1:0] sample,
    output logic              full,
    output logic [DATA_W-1:0] dc,
    output logic [DATA_W-1:0] ac
);
    localparam int SUM_W = DATA_W + WINDOW_LOG2;
    localparam logic [WINDOW_LOG2:0] CNT_FULL = (WINDOW_LOG2+1)'(1) << WINDOW_LOG2;

    logic [SUM_W-1:0]     sum;
    logic [DATA_W-1:0]    min_v;
    logic [DATA_W-1:0]    max_v;
    logic [WINDOW_LOG2:0] cnt;

    // A strobe coinciding with a clear seeds the next window instead of being lost.
    always_ff @(posedge CLK) begin
        if (rst || (clr && !stb)) begin
            sum   <= '0;
            min_v <= '1;
            max_v <= '0;
            cnt   <= '0;
        end else if (clr) begin
            sum   <= SUM_W'(sample);
            min_v <= sample;
            max_v <= sample;
            cnt   <= (WINDOW_LOG2+1)'(1);
        end else if (stb && !full) begin
            sum <= sum + SUM_W'(sample);
            if (sample < min_v) min_v <= sample;
            if (sample > max_v) max_v <= sample;
            cnt <= cnt + 1'b1;
        end
    end

    assign full = (cnt == CNT_FULL);
    assign dc   = DATA_W'(sum >> WINDOW_LOG2);
    assign ac   = max_v - min_v;

endmodule

// File: rtl/ppg_window_stats.sv
// Per-window RED/IR mean and peak-to-peak statistics for the SpO2 ratio stage.
// Latency: record registered two cycles after both channels reach a full window.
// Backpressure: record held until accepted; a window finishing meanwhile is dropped and flags Overrun.
module ppg_window_stats
    import ppg_pkg::*;
#(
    parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      Enable,
    input  logic                      LED_RED,
    input  logic                      LED_IR,
    input  logic [DATA_W-1:0]         RED_ADC_Value,
    input  logic [DATA_W-1:0]         IR_ADC_Value,
    ppg_window_stats_if.master        stats,
    output logic                      Overrun
);
    ppg_state_t state;
    ppg_rec_t   rec_q;
    logic       led_red_q, led_ir_q;
    logic       vld_q, ovr_q;
    logic       red_stb, ir_stb, acc_clr;
    logic       red_full, ir_full;
    logic [DATA_W-1:0] red_dc, red_ac, ir_dc, ir_ac;

    // The controller latches the ADC value as it drops the LED, so the falling edge marks a valid sample.
    assign red_stb = led_red_q & ~LED_RED & (state != IDLE);
    assign ir_stb  = led_ir_q  & ~LED_IR  & (state != IDLE);
    assign acc_clr = (state != ACCUM);

    ppg_chan_acc #(.WINDOW_LOG2(WINDOW_LOG2), .DATA_W(DATA_W)) u_red (
        .CLK(CLK), .rst(rst), .clr(acc_clr), .stb(red_stb), .sample(RED_ADC_Value),
        .full(red_full), .dc(red_dc), .ac(red_ac)
    );

    ppg_chan_acc #(.WINDOW_LOG2(WINDOW_LOG2), .DATA_W(DATA_W)) u_ir (
        .CLK(CLK), .rst(rst), .clr(acc_clr), .stb(ir_stb), .sample(IR_ADC_Value),
        .full(ir_full), .dc(ir_dc), .ac(ir_ac)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= IDLE;
            led_red_q <= 1'b0;
            led_ir_q  <= 1'b0;
            vld_q     <= 1'b0;
            ovr_q     <= 1'b0;
            rec_q     <= '0;
        end else begin
            led_red_q <= LED_RED;
            led_ir_q  <= LED_IR;
            if (vld_q && stats.Stats_Ready) vld_q <= 1'b0;
            case (state)
                IDLE: if (Enable) state <= ACCUM;
                ACCUM: begin
                    if (!Enable)                 state <= IDLE;
                    else if (red_full && ir_full) state <= LOAD;
                end
                LOAD: begin
                    if (!vld_q || stats.Stats_Ready) begin
                        rec_q <= '{red_dc: red_dc, red_ac: red_ac, ir_dc: ir_dc, ir_ac: ir_ac};
                        vld_q <= 1'b1;
                    end else begin
                        ovr_q <= 1'b1;
                    end
                    state <= Enable ? ACCUM : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stats.Stats_Valid = vld_q;
    assign stats.RED_DC      = rec_q.red_dc;
    assign stats.RED_AC      = rec_q.red_ac;
    assign stats.IR_DC       = rec_q.ir_dc;
    assign stats.IR_AC       = rec_q.ir_ac;
    assign Overrun           = ovr_q;

endmodule

// File: doc/ppg_window_stats.md
Name: ppg_window_stats

Overview:
- Downstream of the LED/gain controller; consumes its RED_ADC_Value / IR_ADC_Value streams once the controller is alternating the LEDs.
- Accumulates per-channel statistics over a window of 2^WINDOW_LOG2 samples: mean (DC level), min, max and peak-to-peak (AC level).
- Presents one result record per window to the SpO2/ratio stage through a valid/ready handshake.

Parameters:
- WINDOW_LOG2, 6, log2 of samples per channel per window (64 samples, about 1.28 s at 50 Hz per channel).
- DATA_W, 8, ADC sample width.

Ports:
- CLK  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- Enable  in  1  high while the controller is in its LED-alternating phase. Low discards any partial window.
- LED_RED  in  1  controller RED LED drive; used for the sample strobe.
- LED_IR  in  1  controller IR LED drive; used for the sample strobe.
- RED_ADC_Value  in  DATA_W  latched RED sample from the controller.
- IR_ADC_Value  in  DATA_W  latched IR sample from the controller.
- Stats_Ready  in  1  consumer accepts the record.
- Stats_Valid  out  1  record available; held until accepted.
- RED_DC  out  DATA_W  RED window mean.
- RED_AC  out  DATA_W  RED max minus min.
- IR_DC  out  DATA_W  IR window mean.
- IR_AC  out  DATA_W  IR max minus min.
- Overrun  out  1  sticky; set when a window completes while the previous record is still unaccepted.

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators cleared. Reset mid-window or mid-report discards everything.
- Strobes:
  - LED_RED and LED_IR are registered once.
  - red_stb = previous LED_RED high and current LED_RED low. The controller latches RED_ADC_Value on the same edge on which it drops LED_RED, so the value is stable when red_stb is seen.
  - ir_stb is the same rule applied to LED_IR.
  - Sample capture happens in the cycle red_stb / ir_stb is high.
- Per-channel accumulator:
  - sum: DATA_W+WINDOW_LOG2 bits; cannot overflow.
  - min: initialised to 2^DATA_W-1. max: initialised to 0.
  - cnt: WINDOW_LOG2+1 bits.
  - On a strobe with cnt < 2^WINDOW_LOG2: sum += sample, min/max updated, cnt++.
  - A strobe with cnt already full is ignored. The sample is dropped and no error is raised.
  - Red and IR strobes in the same cycle are both captured independently.
- States:
  - IDLE: accumulators cleared. Goes to ACCUM when Enable is 1.
  - ACCUM:
    - Goes to IDLE when Enable is 0 (partial window dropped, no record).
    - When both cnt equal 2^WINDOW_LOG2, goes to LOAD next cycle.
  - LOAD (1 cycle):
    - If Stats_Valid is 0 or (Stats_Valid and Stats_Ready): output registers are written, Stats_Valid = 1.
      - DC = sum >> WINDOW_LOG2 (truncating).
      - AC = max - min, always ≥ 0.
    - Otherwise the new record is dropped and Overrun = 1.
    - Accumulators are cleared. Goes to ACCUM if Enable, else IDLE.
- Latency: record visible 2 cycles after the strobe that completes the second channel (1 cycle edge detect into ACCUM, LOAD, then register).
- Handshake:
  - Transfer occurs when Stats_Valid and Stats_Ready are both 1; Stats_Valid drops the next cycle unless LOAD writes a new record that same cycle.
  - Outputs are stable while Stats_Valid=1 and Stats_Ready=0.
  - Enable low does not cancel a pending record.
- Overrun clears only on rst.
- A strobe arriving during the LOAD cycle counts toward the new window (clear takes priority, then that sample is added).

Decomposition:
- Package ppg_pkg:
  - state enum {IDLE, ACCUM, LOAD};
  - WINDOW_LOG2 / DATA_W defaults;
  - record struct {red_dc, red_ac, ir_dc, ir_ac}.
- Sub-module ppg_chan_acc, instantiated twice: one channel's sum/min/max/cnt, with inputs clr, stb, sample and outputs full, dc, ac.

Test Plan:
- Reset hold → all outputs 0, Stats_Valid 0, Overrun 0.
- WINDOW_LOG2=2, Enable=1, Stats_Ready=1, RED samples 10,20,30,40 and IR samples 100 constant → RED_DC=25, RED_AC=30, IR_DC=100, IR_AC=0, Stats_Valid pulses one cycle.
- Stats_Ready=0 for two full windows → first record held unchanged, Overrun=1 after the second window completes, second record not visible.
- Enable dropped after 3 of 4 samples, then re-enabled with 4 samples of 50 → single record with DC=50, AC=0 (old samples not included).
- Extra 5th RED strobe before the 4th IR strobe (RED samples 0,0,0,0 then 255) → RED_AC=0 (fifth sample ignored).
- All samples 255, WINDOW_LOG2=6 → DC=255 (no sum overflow), AC=0. Also assert rst during LOAD → no record is produced.
